// File: rtl/fphub_result_stage.sv
// rtl/fphub_result_stage.sv - registered two-entry skid output stage for FPHUB adder results
// Classifies each accepted word, keeps sticky inf/NaN flags and a saturating handshake count.
module fphub_result_stage #(
   parameter int M     = 23,
   parameter int E     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [E+M:0]     in_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [E+M:0]     out_z,
   output logic [3:0]       out_flags,
   input  logic             clear_sticky,
   output logic             sticky_inf,
   output logic             sticky_nan,
   output logic [CNT_W-1:0] result_count
);

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

   state_t           state_q, state_d;
   logic [E+M:0]     main_z_q, main_z_d;
   logic [3:0]       main_f_q, main_f_d;
   logic [E+M:0]     skid_z_q, skid_z_d;
   logic [3:0]       skid_f_q, skid_f_d;
   logic             sticky_inf_q, sticky_inf_d;
   logic             sticky_nan_q, sticky_nan_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [E-1:0]     in_exp;
   logic [M-1:0]     in_man;
   logic [3:0]       in_flags;
   logic             accept;
   logic             emit;

   assign in_exp   = in_z[E+M-1:M];
   assign in_man   = in_z[M-1:0];
   assign in_flags = {in_z[E+M],
                      (&in_exp) & (|in_man),
                      (&in_exp) & ~(|in_man),
                      ~(|in_exp)};

   // Both handshake qualifiers depend only on registered state.
   assign in_ready  = (state_q != S_FULL);
   assign out_valid = (state_q != S_EMPTY);
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   assign out_z        = main_z_q;
   assign out_flags    = main_f_q;
   assign sticky_inf   = sticky_inf_q;
   assign sticky_nan   = sticky_nan_q;
   assign result_count = count_q;

   always_comb begin
      state_d  = state_q;
      main_z_d = main_z_q;
      main_f_d = main_f_q;
      skid_z_d = skid_z_q;
      skid_f_d = skid_f_q;
      unique case (state_q)
         S_EMPTY: begin
            if (accept) begin
               state_d  = S_ONE;
               main_z_d = in_z;
               main_f_d = in_flags;
            end
         end
         S_ONE: begin
            if (accept && emit) begin
               main_z_d = in_z;
               main_f_d = in_flags;
            end else if (accept) begin
               state_d  = S_FULL;
               skid_z_d = in_z;
               skid_f_d = in_flags;
            end else if (emit) begin
               state_d  = S_EMPTY;
            end
         end
         S_FULL: begin
            if (emit) begin
               state_d  = S_ONE;
               main_z_d = skid_z_q;
               main_f_d = skid_f_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // A flag set on this cycle's accept takes priority over a simultaneous clear.
   always_comb begin
      sticky_inf_d = clear_sticky ? 1'b0 : sticky_inf_q;
      sticky_nan_d = clear_sticky ? 1'b0 : sticky_nan_q;
      if (accept && in_flags[1]) sticky_inf_d = 1'b1;
      if (accept && in_flags[2]) sticky_nan_d = 1'b1;
   end

   always_comb begin
      count_d = count_q;
      if (emit && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_EMPTY;
         main_z_q     <= '0;
         main_f_q     <= '0;
         skid_z_q     <= '0;
         skid_f_q     <= '0;
         sticky_inf_q <= 1'b0;
         sticky_nan_q <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         main_z_q     <= main_z_d;
         main_f_q     <= main_f_d;
         skid_z_q     <= skid_z_d;
         skid_f_q     <= skid_f_d;
         sticky_inf_q <= sticky_inf_d;
         sticky_nan_q <= sticky_nan_d;
         count_q      <= count_d;
      end
   end

endmodule
